dragon_hit_responder: RTL and testbench

DRAGON_HIT_RESPONDER -- requirements
Module: dragon_hit_responder

---
 rtl/dragon_pkg.sv | 19 +
 rtl/frame_collision_latch.sv | 33 +++
 rtl/dragon_hit_responder.sv | 130 +++++++++++++
 tb/tb_dragon_hit_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragon_pkg.sv
// Shared types and screen limits for the dragon hit responder.
package dragon_pkg;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        COOLDOWN = 2'd1,
        DYING    = 2'd2,
        DEFEATED = 2'd3
    } dragon_state_t;

    // Dragon counts as on-screen strictly between these bounds.
    localparam int SCREEN_X_MIN = -50;
    localparam int SCREEN_X_MAX = 640;

    function automatic logic on_screen(input logic signed [10:0] x);
        return (int'(x) > SCREEN_X_MIN) && (int'(x) < SCREEN_X_MAX);
    endfunction

endpackage

// File: rtl/frame_collision_latch.sv
// Sticky per-frame collision flags; a pixel seen on the startOfFrame cycle
// seeds the new frame while the registered values still describe the old one.
module frame_collision_latch (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic dragonDR,
    input  logic spellDR,
    input  logic playerDR,
    output logic spellColl,
    output logic playerColl
);

    logic spell_px;
    logic player_px;

    assign spell_px  = dragonDR & spellDR;
    assign player_px = dragonDR & playerDR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spellColl  <= 1'b0;
            playerColl <= 1'b0;
        end else if (startOfFrame) begin
            spellColl  <= spell_px;
            playerColl <= player_px;
        end else begin
            spellColl  <= spellColl | spell_px;
            playerColl <= playerColl | player_px;
        end
    end

endmodule

// File: rtl/dragon_hit_responder.sv
// Dragon damage/invulnerability/death sequencer, evaluated once per frame.
//   state    | meaning
//   ALIVE    | vulnerable, spell hits accepted
//   COOLDOWN | invulnerable for a frame count after a non-fatal hit
//   DYING    | death animation, frame count then DEFEATED
//   DEFEATED | terminal until reset
module dragon_hit_responder
    import dragon_pkg::*;
#(
    parameter int MAX_HEALTH      = 3,
    parameter int COOLDOWN_FRAMES = 32,
    parameter int DEATH_FRAMES    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               pause,
    input  logic               dragonDR,
    input  logic               spellDR,
    input  logic               playerDR,
    input  logic signed [10:0] dragonTopLeftX,
    output logic               dragonHit,
    output logic               playerHit,
    output logic [2:0]         dragonHealth,
    output logic               dragonVisible,
    output logic               dragonDefeated
);

    localparam logic [2:0] HEALTH_INIT = 3'(MAX_HEALTH);
    localparam logic [7:0] COOL_LOAD   = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] DEATH_LOAD  = 8'(DEATH_FRAMES);

    dragon_state_t state, state_nxt;
    logic [7:0]    counter, counter_nxt;
    logic [2:0]    health, health_nxt;
    logic          dragon_hit_nxt, player_hit_nxt;
    logic          spellColl, playerColl;
    logic          evaluate, spell_hit, player_touch;

    frame_collision_latch u_latch (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .dragonDR     (dragonDR),
        .spellDR      (spellDR),
        .playerDR     (playerDR),
        .spellColl    (spellColl),
        .playerColl   (playerColl)
    );

    assign evaluate     = startOfFrame & ~pause;
    assign spell_hit    = spellColl & on_screen(dragonTopLeftX);
    assign player_touch = playerColl & on_screen(dragonTopLeftX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ALIVE;
            counter   <= 8'd0;
            health    <= HEALTH_INIT;
            dragonHit <= 1'b0;
            playerHit <= 1'b0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            health    <= health_nxt;
            dragonHit <= dragon_hit_nxt;
            playerHit <= player_hit_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        counter_nxt    = counter;
        health_nxt     = health;
        dragon_hit_nxt = 1'b0;
        player_hit_nxt = 1'b0;
        if (evaluate) begin
            case (state)
                ALIVE: begin
                    player_hit_nxt = player_touch;
                    if (spell_hit) begin
                        dragon_hit_nxt = 1'b1;
                        if (health <= 3'd1) begin
                            health_nxt  = 3'd0;
                            state_nxt   = DYING;
                            counter_nxt = DEATH_LOAD;
                        end else begin
                            health_nxt  = health - 3'd1;
                            state_nxt   = COOLDOWN;
                            counter_nxt = COOL_LOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    player_hit_nxt = player_touch;
                    if (counter <= 8'd1) begin
                        counter_nxt = 8'd0;
                        state_nxt   = ALIVE;
                    end else begin
                        counter_nxt = counter - 8'd1;
                    end
                end
                DYING: begin
                    if (counter <= 8'd1) begin
                        counter_nxt = 8'd0;
                        state_nxt   = DEFEATED;
                    end else begin
                        counter_nxt = counter - 8'd1;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_comb begin
        case (state)
            ALIVE:    dragonVisible = 1'b1;
            COOLDOWN: dragonVisible = ~counter[1];
            DYING:    dragonVisible = ~counter[1];
            default:  dragonVisible = 1'b0;
        endcase
    end

    assign dragonHealth   = health;
    assign dragonDefeated = (state == DEFEATED);

endmodule

// File: tb/tb_dragon_hit_responder.sv
// Scoreboard bench: frame-level reference model pushes expectations, monitor pops after each startOfFrame.
module tb_dragon_hit_responder;

    localparam int MAXH  = 3;
    localparam int COOL  = 32;
    localparam int DEATH = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame, pause, dragonDR, spellDR, playerDR;
    logic signed [10:0] dragonTopLeftX;
    logic               dragonHit, playerHit, dragonVisible, dragonDefeated;
    logic [2:0]         dragonHealth;

    dragon_hit_responder #(
        .MAX_HEALTH(MAXH), .COOLDOWN_FRAMES(COOL), .DEATH_FRAMES(DEATH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .pause          (pause),
        .dragonDR       (dragonDR),
        .spellDR        (spellDR),
        .playerDR       (playerDR),
        .dragonTopLeftX (dragonTopLeftX),
        .dragonHit      (dragonHit),
        .playerHit      (playerHit),
        .dragonHealth   (dragonHealth),
        .dragonVisible  (dragonVisible),
        .dragonDefeated (dragonDefeated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dh;
        logic       ph;
        logic [2:0] health;
        logic       vis;
        logic       dead;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hit_count = 0;

    // Reference model: health, frames of invulnerability left, frames of dying left, defeated flag.
    int m_health, m_cool, m_dying;
    bit m_dead, m_sp, m_pl;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit m_visible();
        if (m_dead) return 1'b0;
        if (m_dying > 0) return !m_dying[1];
        if (m_cool > 0) return !m_cool[1];
        return 1'b1;
    endfunction

    function automatic void model_init();
        m_health = MAXH;
        m_cool   = 0;
        m_dying  = 0;
        m_dead   = 1'b0;
        m_sp     = 1'b0;
        m_pl     = 1'b0;
    endfunction

    function automatic void model_sof(input int x, input bit pse);
        exp_t e;
        bit on, s, p, dh, ph;
        dh = 1'b0;
        ph = 1'b0;
        if (!pse) begin
            on = (x > -50) && (x < 640);
            s  = m_sp && on;
            p  = m_pl && on;
            if (m_dead) begin
            end else if (m_dying > 0) begin
                m_dying--;
                if (m_dying == 0) m_dead = 1'b1;
            end else begin
                ph = p;
                if (m_cool > 0) begin
                    m_cool--;
                end else if (s) begin
                    dh = 1'b1;
                    m_health--;
                    if (m_health == 0) m_dying = DEATH;
                    else m_cool = COOL;
                end
            end
        end
        e.dh     = dh;
        e.ph     = ph;
        e.health = 3'(m_health);
        e.vis    = m_visible();
        e.dead   = m_dead;
        exp_q.push_back(e);
    endfunction

    logic sof_d;
    always @(posedge clk or posedge reset) begin
        if (reset) sof_d <= 1'b0;
        else sof_d <= startOfFrame;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (dragonHit) hit_count++;
            if (sof_d) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got output with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("dragonHit",      8'(dragonHit),      8'(e.dh));
                    chk("playerHit",      8'(playerHit),      8'(e.ph));
                    chk("dragonHealth",   8'(dragonHealth),   8'(e.health));
                    chk("dragonVisible",  8'(dragonVisible),  8'(e.vis));
                    chk("dragonDefeated", 8'(dragonDefeated), 8'(e.dead));
                end
            end else begin
                chk("idle_dragonHit", 8'(dragonHit), 8'd0);
                chk("idle_playerHit", 8'(playerHit), 8'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        startOfFrame = 1'b0;
        pause = 1'b0;
        dragonDR = 1'b0;
        spellDR = 1'b0;
        playerDR = 1'b0;
        #1;
        chk("rst_health",   8'(dragonHealth),   8'(MAXH));
        chk("rst_visible",  8'(dragonVisible),  8'd1);
        chk("rst_defeated", 8'(dragonDefeated), 8'd0);
        chk("rst_dragonHit", 8'(dragonHit),     8'd0);
        chk("rst_playerHit", 8'(playerHit),     8'd0);
        exp_q.delete();
        model_init();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic frame(input bit sp, input bit pl, input int x, input bit pse, input bit rnd);
        bit d, s, p;
        @(negedge clk);
        dragonTopLeftX = 11'(x);
        pause = pse;
        d = rnd && ($urandom_range(0, 2) == 0);
        s = rnd && ($urandom_range(0, 2) == 0);
        p = rnd && ($urandom_range(0, 2) == 0);
        startOfFrame = 1'b1;
        dragonDR = d;
        spellDR = s;
        playerDR = p;
        model_sof(x, pse);
        m_sp = d & s;
        m_pl = d & p;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            startOfFrame = 1'b0;
            d = rnd && ($urandom_range(0, 5) == 0);
            s = rnd && ($urandom_range(0, 5) == 0);
            p = rnd && ($urandom_range(0, 5) == 0);
            if (sp && c == 1) begin d = 1'b1; s = 1'b1; end
            if (pl && c == 2) begin d = 1'b1; p = 1'b1; end
            dragonDR = d;
            spellDR = s;
            playerDR = p;
            m_sp = m_sp | (d & s);
            m_pl = m_pl | (d & p);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xs[8];
        xs = '{-60, -50, -49, 0, 320, 639, 640, 680};
        reset = 1'b1;
        startOfFrame = 1'b0;
        pause = 1'b0;
        dragonDR = 1'b0;
        spellDR = 1'b0;
        playerDR = 1'b0;
        dragonTopLeftX = 11'sd100;
        model_init();
        #12;
        do_reset();

        // Single overlap pixel then evaluation frame.
        frame(1, 0, 100, 0, 0);
        frame(0, 0, 100, 0, 0);
        frame(0, 0, 100, 0, 0);

        // Spell and player together in ALIVE.
        do_reset();
        frame(1, 1, 100, 0, 0);
        frame(0, 0, 100, 0, 0);

        // Off-screen bounds, then on-screen edges.
        do_reset();
        frame(1, 1, 680, 0, 0);
        frame(1, 1, -50, 0, 0);
        frame(1, 1, 640, 0, 0);
        frame(1, 1, -49, 0, 0);
        frame(0, 1, 639, 0, 0);
        frame(0, 0, 639, 0, 0);

        // Pause across 10 frames in COOLDOWN, then release.
        do_reset();
        frame(1, 0, 100, 0, 0);
        frame(0, 0, 100, 0, 0);
        for (int i = 0; i < 10; i++) frame(1, 1, 100, 1, 0);
        for (int i = 0; i < 36; i++) frame(1, 0, 100, 0, 0);

        // Overlap every frame until DEFEATED.
        do_reset();
        hit_count = 0;
        for (int i = 0; i < 90; i++) frame(1, 1, 100, 0, 0);
        frame(0, 0, 100, 0, 0);
        chk("seq_hits",     8'(hit_count),      8'd3);
        chk("seq_health",   8'(dragonHealth),   8'd0);
        chk("seq_defeated", 8'(dragonDefeated), 8'd1);

        // Reset in the middle of DYING.
        do_reset();
        for (int i = 0; i < 72; i++) frame(1, 0, 100, 0, 0);
        do_reset();
        frame(1, 0, 100, 0, 0);
        frame(0, 0, 100, 0, 0);

        // Randomized frames.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 120; i++)
                frame($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      xs[$urandom_range(0, 7)], $urandom_range(0, 9) == 0, 1);
        end

        frame(0, 0, 100, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
